// File: rtl/ysyx_23060061_axi_arbiter.sv
// ysyx_23060061_axi_arbiter: shares one AXI4 slave port between IFU (M0, read) and LSU (M1, read/write)
// One whole transaction owns the bus at a time; round-robin between masters.
module ysyx_23060061_axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [3:0]          m0_arid,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic [3:0]          m0_rid,
   output logic                m0_rlast,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [3:0]          m1_arid,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic [3:0]          m1_rid,
   output logic                m1_rlast,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [3:0]          m1_awid,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic [3:0]          m1_bid,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [3:0]          s_arid,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic [3:0]          s_rid,
   input  logic                s_rlast,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [3:0]          s_awid,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic [3:0]          s_bid,
   input  logic                s_bvalid,
   output logic                s_bready
);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t state_q, state_d;
   logic owner_q, owner_d, last_q, last_d;
   logic ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic rd, wr, rd0, rd1, w1, m1_req, g, b_ok, rd_end, wr_end;

   assign rd = state_q == RD;
   assign wr = state_q == WR;
   assign rd0 = rd & ~owner_q;
   assign rd1 = rd & owner_q;
   assign w1 = m1_awvalid | m1_wvalid;
   assign m1_req = m1_arvalid | w1;
   // On a tie the master that did not win last time gets the bus
   assign g = (m0_arvalid & m1_req) ? ~last_q : m1_req;
   assign b_ok = wr & aw_done_q & w_done_q;
   assign rd_end = rd & s_rvalid & s_rready & s_rlast & ar_done_q;
   assign wr_end = s_bvalid & s_bready;

   assign s_araddr   = rd1 ? m1_araddr  : rd0 ? m0_araddr  : '0;
   assign s_arid     = rd1 ? m1_arid    : rd0 ? m0_arid    : '0;
   assign s_arlen    = rd1 ? m1_arlen   : rd0 ? m0_arlen   : '0;
   assign s_arsize   = rd1 ? m1_arsize  : rd0 ? m0_arsize  : '0;
   assign s_arburst  = rd1 ? m1_arburst : rd0 ? m0_arburst : '0;
   assign s_arvalid  = ~ar_done_q & (rd1 ? m1_arvalid : rd0 & m0_arvalid);
   assign m0_arready = rd0 & s_arready & ~ar_done_q;
   assign m1_arready = rd1 & s_arready & ~ar_done_q;
   assign s_rready   = rd1 ? m1_rready : rd0 & m0_rready;
   assign m0_rvalid  = rd0 & s_rvalid;
   assign m0_rdata   = rd0 ? s_rdata : '0;
   assign m0_rresp   = rd0 ? s_rresp : '0;
   assign m0_rid     = rd0 ? s_rid   : '0;
   assign m0_rlast   = rd0 & s_rlast;
   assign m1_rvalid  = rd1 & s_rvalid;
   assign m1_rdata   = rd1 ? s_rdata : '0;
   assign m1_rresp   = rd1 ? s_rresp : '0;
   assign m1_rid     = rd1 ? s_rid   : '0;
   assign m1_rlast   = rd1 & s_rlast;

   assign s_awaddr   = wr ? m1_awaddr  : '0;
   assign s_awid     = wr ? m1_awid    : '0;
   assign s_awlen    = wr ? m1_awlen   : '0;
   assign s_awsize   = wr ? m1_awsize  : '0;
   assign s_awburst  = wr ? m1_awburst : '0;
   assign s_awvalid  = wr & ~aw_done_q & m1_awvalid;
   assign m1_awready = wr & ~aw_done_q & s_awready;
   assign s_wdata    = wr ? m1_wdata : '0;
   assign s_wstrb    = wr ? m1_wstrb : '0;
   assign s_wlast    = wr & m1_wlast;
   assign s_wvalid   = wr & ~w_done_q & m1_wvalid;
   assign m1_wready  = wr & ~w_done_q & s_wready;
   // B is only exposed once both address and data have been handed over
   assign s_bready   = b_ok & m1_bready;
   assign m1_bvalid  = b_ok & s_bvalid;
   assign m1_bresp   = b_ok ? s_bresp : '0;
   assign m1_bid     = b_ok ? s_bid   : '0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d = last_q;
      ar_done_d = ar_done_q | (s_arvalid & s_arready);
      aw_done_d = aw_done_q | (s_awvalid & s_awready);
      w_done_d = w_done_q | (s_wvalid & s_wready);
      if (state_q == IDLE && (m0_arvalid | m1_req)) begin
         state_d = (g & w1) ? WR : RD;
         owner_d = g;
         last_d = g;
         ar_done_d = 1'b0;
         aw_done_d = 1'b0;
         w_done_d = 1'b0;
      end
      if (rd_end | wr_end) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q <= 1'b0;
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q <= last_d;
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q <= w_done_d;
      end
   end
endmodule

// File: tb/tb_ysyx_23060061_axi_arbiter.sv
// tb_ysyx_23060061_axi_arbiter: directed checks of grant order, routing, write gating and reset
module tb_ysyx_23060061_axi_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] m0_araddr = '0, m1_araddr = '0, m1_awaddr = '0, m1_wdata = '0;
   logic [3:0] m0_arid = '0, m1_arid = '0, m1_awid = '0, m1_wstrb = '0;
   logic [7:0] m0_arlen = '0, m1_arlen = '0, m1_awlen = '0;
   logic [2:0] m0_arsize = 3'd2, m1_arsize = 3'd2, m1_awsize = 3'd2;
   logic [1:0] m0_arburst = 2'd1, m1_arburst = 2'd1, m1_awburst = 2'd1;
   logic m0_arvalid = 0, m0_rready = 0, m1_arvalid = 0, m1_rready = 0;
   logic m1_awvalid = 0, m1_wlast = 0, m1_wvalid = 0, m1_bready = 0;
   logic s_arready = 0, s_rlast = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0] s_rresp = '0, s_bresp = '0;
   logic [3:0] s_rid = '0, s_bid = '0;
   logic m0_arready, m0_rlast, m0_rvalid, m1_arready, m1_rlast, m1_rvalid;
   logic m1_awready, m1_wready, m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;
   logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
   logic [1:0] m0_rresp, m1_rresp, m1_bresp, s_arburst, s_awburst;
   logic [3:0] m0_rid, m1_rid, m1_bid, s_arid, s_awid, s_wstrb;
   logic [7:0] s_arlen, s_awlen;
   logic [2:0] s_arsize, s_awsize;
   int total = 0, bad = 0;

   ysyx_23060061_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
      .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rid(m0_rid), .m0_rlast(m0_rlast),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
      .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rid(m1_rid), .m1_rlast(m1_rlast),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
      .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
      .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bid(m1_bid), .m1_bvalid(m1_bvalid),
      .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid),
      .s_bready(s_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive a single read beat, let it settle, and leave it asserted for the caller to check
   task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] r);
      s_rvalid = 1;
      s_rdata = d;
      s_rlast = l;
      s_rresp = r;
      #1;
   endtask

   initial begin
      tick();
      tick();
      rst = 0;
      #1;
      chk("rst_arvalid", s_arvalid, 0);
      chk("rst_awvalid", s_awvalid, 0);
      chk("rst_rready", s_rready, 0);
      chk("rst_bready", s_bready, 0);
      // single-beat M0 read
      tick();
      m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arid = 4'd2; m0_rready = 1;
      #1;
      chk("m0_no_early_ar", s_arvalid, 0);
      tick();
      chk("m0_arvalid", s_arvalid, 1);
      chk("m0_araddr", s_araddr, 32'h8000_0000);
      chk("m0_arid", s_arid, 2);
      s_arready = 1;
      #1;
      chk("m0_arready", m0_arready, 1);
      chk("m1_arready_idle", m1_arready, 0);
      tick();
      m0_arvalid = 0; s_arready = 0;
      beat(32'h0000_0413, 1, 2'd0);
      chk("m0_ar_dropped", s_arvalid, 0);
      chk("m0_rvalid", m0_rvalid, 1);
      chk("m0_rdata", m0_rdata, 32'h0000_0413);
      chk("m0_rlast", m0_rlast, 1);
      chk("m1_rvalid_quiet", m1_rvalid, 0);
      tick();
      s_rvalid = 0; s_rlast = 0;
      #1;
      chk("m0_idle_rready", s_rready, 0);
      // tie: M1 first, then M0 pending ties against a fresh M1 and wins
      m0_arvalid = 1; m0_araddr = 32'hA0; m1_arvalid = 1; m1_araddr = 32'hA1; m1_rready = 1;
      tick();
      chk("tie1_addr", s_araddr, 32'hA1);
      s_arready = 1;
      #1;
      chk("tie1_m0_ready", m0_arready, 0);
      chk("tie1_m1_ready", m1_arready, 1);
      tick();
      m1_arvalid = 0; s_arready = 0;
      beat(32'h11, 1, 2'd0);
      chk("tie1_m1_rvalid", m1_rvalid, 1);
      chk("tie1_m0_rvalid", m0_rvalid, 0);
      tick();
      s_rvalid = 0; s_rlast = 0;
      m1_arvalid = 1; m1_araddr = 32'hA2;
      tick();
      chk("tie2_addr", s_araddr, 32'hA0);
      s_arready = 1;
      tick();
      m0_arvalid = 0; s_arready = 0;
      beat(32'h22, 1, 2'd0);
      chk("tie2_m0_rdata", m0_rdata, 32'h22);
      tick();
      s_rvalid = 0; s_rlast = 0;
      tick();
      chk("tie2_then_m1", s_araddr, 32'hA2);
      s_arready = 1;
      tick();
      m1_arvalid = 0; s_arready = 0;
      beat(32'h33, 1, 2'd0);
      tick();
      s_rvalid = 0; s_rlast = 0;
      // M1 write, AW accepted two cycles before W
      m1_awvalid = 1; m1_awaddr = 32'hA000_03F8; m1_awid = 4'd3;
      m1_wvalid = 1; m1_wdata = 32'h41; m1_wstrb = 4'b0001; m1_wlast = 1; m1_bready = 1;
      tick();
      chk("wr_awvalid", s_awvalid, 1);
      chk("wr_awaddr", s_awaddr, 32'hA000_03F8);
      chk("wr_wdata", s_wdata, 32'h41);
      chk("wr_wstrb", s_wstrb, 4'b0001);
      s_awready = 1;
      #1;
      chk("wr_m1_awready", m1_awready, 1);
      tick();
      s_awready = 0; m1_awvalid = 0;
      #1;
      chk("wr_aw_drop", s_awvalid, 0);
      chk("wr_w_still", s_wvalid, 1);
      chk("wr_bready_lo1", s_bready, 0);
      tick();
      s_wready = 1;
      #1;
      chk("wr_m1_wready", m1_wready, 1);
      chk("wr_bready_lo2", s_bready, 0);
      tick();
      s_wready = 0; m1_wvalid = 0;
      s_bvalid = 1; s_bresp = 2'd0; s_bid = 4'd3;
      #1;
      chk("wr_w_drop", s_wvalid, 0);
      chk("wr_bready", s_bready, 1);
      chk("wr_bvalid", m1_bvalid, 1);
      chk("wr_bresp", m1_bresp, 0);
      chk("wr_bid", m1_bid, 3);
      tick();
      s_bvalid = 0;
      #1;
      chk("wr_idle_bready", s_bready, 0);
      // M0 4-beat burst with M1 arriving mid-burst
      m0_arvalid = 1; m0_araddr = 32'h8000_0100; m0_arlen = 8'd3;
      tick();
      chk("burst_arlen", s_arlen, 3);
      s_arready = 1;
      tick();
      m0_arvalid = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            m1_arvalid = 1; m1_araddr = 32'hB0;
         end
         beat(32'h100 + i, i == 3, 2'd0);
         chk("burst_m0_rdata", m0_rdata, 32'h100 + i);
         chk("burst_m1_rvalid", m1_rvalid, 0);
         chk("burst_m1_arready", m1_arready, 0);
         tick();
      end
      s_rvalid = 0; s_rlast = 0;
      #1;
      chk("burst_bubble", m1_arready, 0);
      chk("burst_bubble_ar", s_arvalid, 0);
      tick();
      chk("burst_m1_grant", s_arvalid, 1);
      chk("burst_m1_addr", s_araddr, 32'hB0);
      chk("burst_m1_arready", m1_arready, 1);
      tick();
      m1_arvalid = 0; s_arready = 0;
      // SLVERR passes through untouched
      beat(32'hDEAD, 1, 2'd2);
      chk("slverr_rresp", m1_rresp, 2);
      chk("slverr_rlast", m1_rlast, 1);
      tick();
      s_rvalid = 0; s_rlast = 0; s_rresp = 0;
      #1;
      chk("slverr_idle", s_rready, 0);
      // reset in the middle of a write after AW completed
      m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'hC0;
      tick();
      s_awready = 1;
      tick();
      s_awready = 0; m1_awvalid = 0; rst = 1;
      tick();
      rst = 0; m1_wvalid = 0; s_wready = 1; s_bvalid = 1;
      #1;
      chk("rst_mid_wvalid", s_wvalid, 0);
      chk("rst_mid_awvalid", s_awvalid, 0);
      chk("rst_mid_bready", s_bready, 0);
      chk("rst_mid_wready", m1_wready, 0);
      s_wready = 0; s_bvalid = 0;
      m0_arvalid = 1; m0_araddr = 32'h8000_0200; m0_arlen = 0;
      tick();
      chk("rst_then_m0", s_araddr, 32'h8000_0200);
      s_arready = 1;
      tick();
      m0_arvalid = 0; s_arready = 0;
      beat(32'h55, 1, 2'd0);
      chk("rst_then_rdata", m0_rdata, 32'h55);
      tick();
      s_rvalid = 0; s_rlast = 0;
      // AW and W accepted in the same cycle
      m1_awvalid = 1; m1_wvalid = 1;
      tick();
      s_awready = 1; s_wready = 1;
      tick();
      s_awready = 0; s_wready = 0; m1_awvalid = 0; m1_wvalid = 0;
      #1;
      chk("same_cycle_bready", s_bready, 1);
      s_bvalid = 1;
      tick();
      s_bvalid = 0;
      #1;
      chk("same_cycle_idle", s_bready, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
